// File: rtl/mix_columns_stage_if.sv
// ---------------------------------------------------------------------------
// mix_columns_stage_if
//   Handshake bundle for the iterative AES MixColumns stage.
//   Input side : in_valid / in_ready, in_state (128b), in_bypass, in_tag
//   Output side: out_valid / out_ready, out_state (128b), out_tag
//   modport master : the block feeding the stage and draining its result
//   modport slave  : the MixColumns stage itself
// ---------------------------------------------------------------------------
interface mix_columns_stage_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [127:0]         in_state;
  logic                 in_bypass;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [127:0]         out_state;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_state, in_bypass, in_tag, out_ready,
    input  in_ready, out_valid, out_state, out_tag
  );

  modport slave (
    input  in_valid, in_state, in_bypass, in_tag, out_ready,
    output in_ready, out_valid, out_state, out_tag
  );
endinterface

// File: rtl/mix_columns_stage.sv
// ---------------------------------------------------------------------------
// encryption_functions
//   GF(2^8) helpers shared by the AES datapath stages.
// ---------------------------------------------------------------------------
package encryption_functions;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return mul2(x) ^ x;
  endfunction

  // One MixColumns column; row 0 is the most significant byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    r0 = mul2(s0) ^ mul3(s1) ^ s2       ^ s3;
    r1 = s0       ^ mul2(s1) ^ mul3(s2) ^ s3;
    r2 = s0       ^ s1       ^ mul2(s2) ^ mul3(s3);
    r3 = mul3(s0) ^ s1       ^ s2       ^ mul2(s3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// ---------------------------------------------------------------------------
// mix_columns_stage
//   Iterative AES-128 MixColumns. Accepts one 128-bit state in IDLE, mixes
//   COLS_PER_CYCLE columns per BUSY cycle in place, then presents the result
//   in DONE until the consumer takes it. A bypassed block (final round) goes
//   straight from IDLE to DONE with the state untouched.
//
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mix_columns_stage_if (in_* accept, out_* result)
// ---------------------------------------------------------------------------
module mix_columns_stage
  import encryption_functions::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mix_columns_stage_if.slave     bus
);

  localparam int NUM_COLS = 4;

  // With 4 columns per cycle the step is 4, which wraps the 2-bit counter
  // to 0; the single BUSY cycle then sees col_q == LAST_COL == 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_stage: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [127:0]         work_q,  work_d;
  logic [TAG_WIDTH-1:0] tag_q,   tag_d;
  logic [1:0]           col_q,   col_d;
  logic [6:0]           col_lsb;

  always_comb begin
    // NOTE: every variable gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    state_d = state_q;
    work_d  = work_q;
    tag_d   = tag_q;
    col_d   = col_q;
    col_lsb = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_state;
          tag_d   = bus.in_tag;
          col_d   = '0;
          state_d = bus.in_bypass ? DONE : BUSY;
        end
      end

      BUSY: begin
        // Column c occupies bits [127-32c -: 32]; the counter is always
        // aligned to COLS_PER_CYCLE so col_q+k never exceeds 3.
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          col_lsb = 7'(32 * (NUM_COLS - 1 - (int'(col_q) + k)));
          work_d[col_lsb +: 32] = mix_column(work_q[col_lsb +: 32]);
        end
        col_d = col_q + COL_STEP;
        if (col_q == LAST_COL) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      // NOTE: the 128-bit work register is reset on purpose: out_state is
      // driven straight from it and must read 0 after an aborted block.
      work_q  <= '0;
      tag_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      tag_q   <= tag_d;
      col_q   <= col_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = work_q;
  assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_mix_columns_stage.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_stage
//   Three stage instances (1, 2 and 4 columns per cycle) share one stimulus
//   bus; `sel` picks which one sees in_valid and which one is monitored.
//   Expected results come from a matrix-times-vector GF(2^8) model.
// ---------------------------------------------------------------------------
module tb_mix_columns_stage;

  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_bypass;
  logic           out_ready;
  logic [127:0]   in_state;
  logic [TW-1:0]  in_tag;
  int             sel;

  logic           mon_in_ready;
  logic           mon_out_valid;
  logic [127:0]   mon_out_state;
  logic [TW-1:0]  mon_out_tag;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mix_columns_stage_if #(.TAG_WIDTH(TW)) bus1 ();
  mix_columns_stage_if #(.TAG_WIDTH(TW)) bus2 ();
  mix_columns_stage_if #(.TAG_WIDTH(TW)) bus4 ();

  assign bus1.in_valid  = in_valid && (sel == 0);
  assign bus2.in_valid  = in_valid && (sel == 1);
  assign bus4.in_valid  = in_valid && (sel == 2);
  assign bus1.in_state  = in_state;
  assign bus2.in_state  = in_state;
  assign bus4.in_state  = in_state;
  assign bus1.in_bypass = in_bypass;
  assign bus2.in_bypass = in_bypass;
  assign bus4.in_bypass = in_bypass;
  assign bus1.in_tag    = in_tag;
  assign bus2.in_tag    = in_tag;
  assign bus4.in_tag    = in_tag;
  assign bus1.out_ready = out_ready;
  assign bus2.out_ready = out_ready;
  assign bus4.out_ready = out_ready;

  mix_columns_stage #(.COLS_PER_CYCLE(1), .TAG_WIDTH(TW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mix_columns_stage #(.COLS_PER_CYCLE(2), .TAG_WIDTH(TW)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mix_columns_stage #(.COLS_PER_CYCLE(4), .TAG_WIDTH(TW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always_comb begin
    case (sel)
      0: begin
        mon_in_ready = bus1.in_ready;  mon_out_valid = bus1.out_valid;
        mon_out_state = bus1.out_state; mon_out_tag = bus1.out_tag;
      end
      1: begin
        mon_in_ready = bus2.in_ready;  mon_out_valid = bus2.out_valid;
        mon_out_state = bus2.out_state; mon_out_tag = bus2.out_tag;
      end
      default: begin
        mon_in_ready = bus4.in_ready;  mon_out_valid = bus4.out_valid;
        mon_out_state = bus4.out_state; mon_out_tag = bus4.out_tag;
      end
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic byp);
    logic [7:0] m [4][4];
    logic [7:0] b [16];
    logic [7:0] acc;
    logic [127:0] r;
    m = '{'{8'd2, 8'd3, 8'd1, 8'd1},
          '{8'd1, 8'd2, 8'd3, 8'd1},
          '{8'd1, 8'd1, 8'd2, 8'd3},
          '{8'd3, 8'd1, 8'd1, 8'd2}};
    if (byp) return s;
    for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[row][k], b[4*c + k]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  typedef struct packed {
    logic [127:0]  st;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept one block, count edges after the accept edge until out_valid,
  // then check result and the return to IDLE.
  task automatic run_directed(input string name, input logic [127:0] st, input logic byp,
                              input logic [TW-1:0] tag, input logic [127:0] exp_state,
                              input int exp_lat);
    int lat;
    out_ready = 1'b1;
    check({name, ":in_ready_idle"}, 128'(mon_in_ready), 128'(1));
    in_state = st; in_bypass = byp; in_tag = tag; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_state = rand128(); in_bypass = ~byp; in_tag = ~tag;
    lat = 0;
    while (!mon_out_valid && lat < 10) begin
      check({name, ":in_ready_busy"}, 128'(mon_in_ready), 128'(0));
      tick();
      lat++;
    end
    check({name, ":latency"}, 128'(lat), 128'(exp_lat));
    check({name, ":in_ready_done"}, 128'(mon_in_ready), 128'(0));
    check({name, ":out_state"}, mon_out_state, exp_state);
    check({name, ":out_tag"}, 128'(mon_out_tag), 128'(tag));
    tick();
    check({name, ":out_valid_drop"}, 128'(mon_out_valid), 128'(0));
    check({name, ":in_ready_back"}, 128'(mon_in_ready), 128'(1));
  endtask

  // Random traffic with random bypass and output stalls; scoreboard order check.
  task automatic run_random(input int sel_i, input int nblocks);
    int    n_acc, n_out, cycles;
    logic  acc, hs;
    logic [TW-1:0] tag_ctr;
    exp_t  e;
    sel = sel_i;
    in_valid = 1'b0;
    n_acc = 0; n_out = 0; cycles = 0; tag_ctr = '0;
    exp_q.delete();
    #1;
    while (n_out < nblocks && cycles < 20 * nblocks + 100) begin
      if (!in_valid && n_acc < nblocks && $urandom_range(0, 3) != 0) begin
        in_state  = rand128();
        in_bypass = ($urandom_range(0, 3) == 0);
        in_tag    = tag_ctr;
        in_valid  = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && mon_in_ready;
      hs  = mon_out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("rnd:unexpected_output", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("rnd:out_state", mon_out_state, e.st);
          check("rnd:out_tag", 128'(mon_out_tag), 128'(e.tag));
        end
        n_out++;
      end
      if (acc) begin
        e.st  = ref_mix(in_state, in_bypass);
        e.tag = in_tag;
        exp_q.push_back(e);
        n_acc++;
        tag_ctr++;
      end
      tick();
      cycles++;
      if (acc) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rnd:blocks_out", 128'(n_out), 128'(nblocks));
    check("rnd:queue_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] st, exp;

    sel = 0; rst_n = 1'b0;
    in_valid = 1'b0; in_state = '0; in_bypass = 1'b0; in_tag = '0; out_ready = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("reset:in_ready", 128'(mon_in_ready), 128'(1));
      check("reset:out_valid", 128'(mon_out_valid), 128'(0));
      check("reset:out_state", mon_out_state, 128'(0));
      check("reset:out_tag", 128'(mon_out_tag), 128'(0));
    end
    sel = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();

    run_directed("fips", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 4'h1,
                 128'h046681e5_e0cb199a_48f8d37a_2806264c, 4);

    sel = 0;
    run_directed("cols_c1", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 4'h2,
                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);
    sel = 1;
    #1;
    run_directed("cols_c2", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 4'h3,
                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 2);
    sel = 2;
    #1;
    run_directed("cols_c4", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 4'h4,
                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1);
    sel = 0;
    #1;

    run_directed("bypass", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 4'h5,
                 128'h00112233_44556677_8899aabb_ccddeeff, 0);

    // Backpressure: result must hold while inputs churn.
    out_ready = 1'b0;
    st = rand128();
    exp = ref_mix(st, 1'b0);
    in_state = st; in_bypass = 1'b0; in_tag = 4'h6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !mon_out_valid; i++) tick();
    check("bp:out_valid", 128'(mon_out_valid), 128'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_state = rand128(); in_bypass = 1'($urandom_range(0, 1));
      in_tag = 4'($urandom);
      tick();
      check("bp:hold_valid", 128'(mon_out_valid), 128'(1));
      check("bp:hold_state", mon_out_state, exp);
      check("bp:hold_tag", 128'(mon_out_tag), 128'(4'h6));
      check("bp:in_ready", 128'(mon_in_ready), 128'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp:release_valid", 128'(mon_out_valid), 128'(0));
    check("bp:release_ready", 128'(mon_in_ready), 128'(1));

    // Reset during the second BUSY cycle.
    in_state = rand128(); in_bypass = 1'b0; in_tag = 4'h7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #2;
    check("rst_mid:out_valid", 128'(mon_out_valid), 128'(0));
    check("rst_mid:out_state", mon_out_state, 128'(0));
    check("rst_mid:out_tag", 128'(mon_out_tag), 128'(0));
    check("rst_mid:in_ready", 128'(mon_in_ready), 128'(1));
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_directed("after_rst", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 4'h8,
                 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4);

    run_random(0, 1000);
    run_random(1, 150);
    run_random(2, 150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
